// File: rtl/mem_arbiter.sv
// mem_arbiter: grants the shared pipelined memory port to the I-cache fill path,
// the D-cache fill path or the D-cache write-through path, one at a time.
// Fills issue BLOCK_WORDS sequential reads and steer the returned words into the
// granted cache; write-through issues one write and waits out the memory latency.
module mem_arbiter #(
    parameter int ADDR_W      = 16,
    parameter int MEM_LAT     = 4,
    parameter int BLOCK_WORDS = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_req,
    input  logic [ADDR_W-1:0]              i_addr,
    input  logic                           d_req,
    input  logic                           d_wr,
    input  logic [ADDR_W-1:0]              d_addr,
    input  logic [15:0]                    d_wdata,
    output logic                           mem_en,
    output logic                           mem_wr,
    output logic [ADDR_W-1:0]              mem_addr,
    output logic [15:0]                    mem_wdata,
    input  logic [15:0]                    mem_rdata,
    input  logic                           mem_valid,
    output logic [15:0]                    fill_data,
    output logic [$clog2(BLOCK_WORDS)-1:0] fill_word,
    output logic                           i_fill_we,
    output logic                           d_fill_we,
    output logic                           i_done,
    output logic                           d_done,
    output logic                           busy
);

    localparam int WORD_W = $clog2(BLOCK_WORDS);
    localparam int CNT_W  = WORD_W + 1;
    localparam int LAT_W  = $clog2(MEM_LAT);

    // Clears the word and byte offset bits so a fill starts at the block boundary.
    localparam logic [ADDR_W-1:0] BLOCK_MASK = ~ADDR_W'(2 * BLOCK_WORDS - 1);
    localparam logic [CNT_W-1:0]  ISSUE_END  = CNT_W'(BLOCK_WORDS);
    localparam logic [WORD_W-1:0] LAST_WORD  = WORD_W'(BLOCK_WORDS - 1);
    localparam logic [LAT_W-1:0]  LAST_WAIT  = LAT_W'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_I_FILL = 2'd1,
        ST_D_FILL = 2'd2,
        ST_WRITE  = 2'd3
    } state_t;

    state_t              state_q,     state_d;
    logic [CNT_W-1:0]    ic_q,        ic_d;        // reads issued so far
    logic [WORD_W-1:0]   rc_q,        rc_d;        // words received so far
    logic [LAT_W-1:0]    wc_q,        wc_d;        // write latency wait counter
    logic                last_fill_q, last_fill_d; // 1'b0 = I filled last, 1'b1 = D
    logic [ADDR_W-1:0]   addr_q,      addr_d;      // block base or write address
    logic [15:0]         wdata_q,     wdata_d;     // latched write-through data

    assign fill_data = mem_rdata;
    assign busy      = (state_q != ST_IDLE);

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ic_q        <= '0;
            rc_q        <= '0;
            wc_q        <= '0;
            last_fill_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= 16'h0000;
        end else begin
            state_q     <= state_d;
            ic_q        <= ic_d;
            rc_q        <= rc_d;
            wc_q        <= wc_d;
            last_fill_q <= last_fill_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
        end
    end

    // Arbitration, next-state and memory/fill output decode.
    always_comb begin
        state_d     = state_q;
        ic_d        = ic_q;
        rc_d        = rc_q;
        wc_d        = wc_q;
        last_fill_d = last_fill_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        mem_en      = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = 16'h0000;
        fill_word   = '0;
        i_fill_we   = 1'b0;
        d_fill_we   = 1'b0;
        i_done      = 1'b0;
        d_done      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ic_d = '0;
                rc_d = '0;
                wc_d = '0;
                if (d_wr) begin
                    state_d = ST_WRITE;
                    addr_d  = d_addr;
                    wdata_d = d_wdata;
                end else if (d_req && (!i_req || (last_fill_q == 1'b0))) begin
                    // D wins when alone or when I had the previous fill.
                    state_d = ST_D_FILL;
                    addr_d  = d_addr & BLOCK_MASK;
                end else if (i_req) begin
                    state_d = ST_I_FILL;
                    addr_d  = i_addr & BLOCK_MASK;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_I_FILL, ST_D_FILL: begin
                if (ic_q < ISSUE_END) begin
                    mem_en   = 1'b1;
                    mem_addr = addr_q + ADDR_W'({ic_q, 1'b0});
                    ic_d     = ic_q + CNT_W'(1);
                end else begin
                    ic_d = ic_q;
                end
                if (mem_valid) begin
                    if (state_q == ST_D_FILL) begin
                        d_fill_we = 1'b1;
                    end else begin
                        i_fill_we = 1'b1;
                    end
                    fill_word = rc_q;
                    rc_d      = rc_q + WORD_W'(1);
                    if (rc_q == LAST_WORD) begin
                        if (state_q == ST_D_FILL) begin
                            d_done = 1'b1;
                        end else begin
                            i_done = 1'b1;
                        end
                        state_d     = ST_IDLE;
                        last_fill_d = (state_q == ST_D_FILL);
                    end else begin
                        state_d = state_q;
                    end
                end else begin
                    rc_d = rc_q;
                end
            end

            ST_WRITE: begin
                if (wc_q == '0) begin
                    mem_en    = 1'b1;
                    mem_wr    = 1'b1;
                    mem_addr  = addr_q;
                    mem_wdata = wdata_q;
                end else begin
                    mem_en = 1'b0;
                end
                wc_d = wc_q + LAT_W'(1);
                if (wc_q == LAST_WAIT) begin
                    d_done  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WRITE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized bench for mem_arbiter. A transaction-level model
// predicts, from the arbitration rules and the documented timeline, every memory
// issue, fill write and done pulse with its cycle number; a monitor pops and
// compares those whenever the DUT shows the corresponding output.
module tb_mem_arbiter;

    localparam int LAT = 4;
    localparam int BW  = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req, d_wr;
    logic [15:0] i_addr, d_addr, d_wdata;
    logic [15:0] mem_rdata;
    logic        mem_valid;
    logic        mem_en, mem_wr;
    logic [15:0] mem_addr, mem_wdata, fill_data;
    logic [2:0]  fill_word;
    logic        i_fill_we, d_fill_we, i_done, d_done, busy;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(16), .MEM_LAT(LAT), .BLOCK_WORDS(BW)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_valid(mem_valid),
        .fill_data(fill_data), .fill_word(fill_word),
        .i_fill_we(i_fill_we), .d_fill_we(d_fill_we),
        .i_done(i_done), .d_done(d_done), .busy(busy)
    );

    typedef struct { int cyc; bit wr; logic [15:0] addr; logic [15:0] wdata; } iss_t;
    typedef struct { int cyc; bit d; logic [2:0] word; logic [15:0] data; } fill_t;
    typedef struct { int cyc; bit d; } done_t;
    typedef struct { int cyc; logic [15:0] data; } rsp_t;

    iss_t  exp_iss[$];
    fill_t exp_fill[$];
    done_t exp_done[$];
    rsp_t  mem_q[$];

    int cyc = 0;
    int errors = 0;
    int checks = 0;
    int grant_cyc = -1;
    int busy_end = 0;
    int free_cyc = 0;
    int hold_until = 0;
    int i_drop = -1;
    int d_drop = -1;
    int rst_chk = -1;
    bit last_d = 1'b0;
    bit stray_en = 1'b0;

    // Cycle number: cycle n is the interval after the n-th rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'hA5A5;
    endfunction

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Memory: every read issued returns its word LAT cycles later.
    always @(negedge clk) begin
        if (cyc >= 1 && mem_en === 1'b1 && mem_wr === 1'b0)
            mem_q.push_back('{cyc + LAT, mem_word(mem_addr)});
    end

    // Monitor: pops expected events and compares them with DUT outputs.
    always @(negedge clk) begin
        iss_t ei;
        fill_t ef;
        done_t ed;
        bit exp_busy;
        if (cyc >= 1) begin
            if (cyc == rst_chk)
                chk({mem_en, mem_wr, mem_addr, mem_wdata, fill_word, i_fill_we, d_fill_we,
                     i_done, d_done, busy} == '0, "reset_outputs",
                    {15'h0, mem_en, mem_wr, fill_word, i_fill_we, d_fill_we, i_done, d_done, busy,
                     mem_addr, mem_wdata}, 64'h0);
            exp_busy = (cyc > grant_cyc) && (cyc < busy_end);
            chk(busy === exp_busy, "busy", {63'h0, busy}, {63'h0, exp_busy});

            while (exp_iss.size() > 0 && exp_iss[0].cyc < cyc) begin
                ei = exp_iss.pop_front();
                chk(1'b0, "issue_missing", 64'h0, {16'(ei.cyc), 15'h0, ei.wr, ei.addr, ei.wdata});
            end
            while (exp_fill.size() > 0 && exp_fill[0].cyc < cyc) begin
                ef = exp_fill.pop_front();
                chk(1'b0, "fill_missing", 64'h0, {16'(ef.cyc), 12'h0, ef.d, ef.word, 16'h0, ef.data});
            end
            while (exp_done.size() > 0 && exp_done[0].cyc < cyc) begin
                ed = exp_done.pop_front();
                chk(1'b0, "done_missing", 64'h0, {16'(ed.cyc), 47'h0, ed.d});
            end

            if (mem_en !== 1'b0) begin
                if (exp_iss.size() == 0 || exp_iss[0].cyc != cyc) begin
                    chk(1'b0, "issue_unexpected", {16'(cyc), 15'h0, mem_wr, mem_addr, mem_wdata}, 64'h0);
                end else begin
                    ei = exp_iss.pop_front();
                    chk(mem_en === 1'b1 && mem_wr === ei.wr && mem_addr === ei.addr &&
                        (!ei.wr || mem_wdata === ei.wdata), "issue",
                        {16'(cyc), 15'h0, mem_wr, mem_addr, mem_wdata},
                        {16'(ei.cyc), 15'h0, ei.wr, ei.addr, ei.wdata});
                end
            end
            if (i_fill_we !== 1'b0 || d_fill_we !== 1'b0) begin
                if (exp_fill.size() == 0 || exp_fill[0].cyc != cyc) begin
                    chk(1'b0, "fill_unexpected", {16'(cyc), 11'h0, i_fill_we, d_fill_we, fill_word, 16'h0, fill_data}, 64'h0);
                end else begin
                    ef = exp_fill.pop_front();
                    chk(d_fill_we === ef.d && i_fill_we === !ef.d && fill_word === ef.word &&
                        fill_data === ef.data, "fill",
                        {16'(cyc), 11'h0, i_fill_we, d_fill_we, fill_word, 16'h0, fill_data},
                        {16'(ef.cyc), 11'h0, !ef.d, ef.d, ef.word, 16'h0, ef.data});
                end
            end
            if (i_done !== 1'b0 || d_done !== 1'b0) begin
                if (exp_done.size() == 0 || exp_done[0].cyc != cyc) begin
                    chk(1'b0, "done_unexpected", {16'(cyc), 46'h0, i_done, d_done}, 64'h0);
                end else begin
                    ed = exp_done.pop_front();
                    chk(d_done === ed.d && i_done === !ed.d, "done",
                        {16'(cyc), 46'h0, i_done, d_done}, {16'(ed.cyc), 46'h0, !ed.d, ed.d});
                end
            end
        end
    end

    // Start of a cycle: release reset, retire requests, drive memory returns.
    task automatic begin_cycle();
        @(posedge clk);
        #1;
        if (rst) begin
            rst = 1'b0;
            rst_chk = cyc;
        end
        if (cyc == i_drop) i_req = 1'b0;
        if (cyc == d_drop) begin
            d_req = 1'b0;
            d_wr  = 1'b0;
        end
        mem_valid = 1'b0;
        mem_rdata = 16'($urandom);
        while (mem_q.size() > 0 && mem_q[0].cyc < cyc) void'(mem_q.pop_front());
        if (mem_q.size() > 0 && mem_q[0].cyc == cyc) begin
            mem_valid = 1'b1;
            mem_rdata = mem_q[0].data;
            void'(mem_q.pop_front());
        end else if (stray_en && cyc >= busy_end && $urandom_range(0, 7) == 0) begin
            mem_valid = 1'b1;
        end
    endtask

    // Reference model: on an idle cycle pick a winner and schedule its timeline.
    task automatic end_cycle();
        logic [15:0] base;
        bit pick_d;
        if (!rst && cyc >= free_cyc) begin
            if (d_wr) begin
                exp_iss.push_back('{cyc + 1, 1'b1, d_addr, d_wdata});
                exp_done.push_back('{cyc + LAT, 1'b1});
                grant_cyc = cyc;
                free_cyc  = cyc + LAT + 1;
                busy_end  = free_cyc;
                d_drop    = free_cyc;
            end else if (d_req || i_req) begin
                if (d_req && i_req) pick_d = !last_d;
                else pick_d = d_req;
                base = (pick_d ? d_addr : i_addr) & ~16'(2 * BW - 1);
                for (int k = 0; k < BW; k++) begin
                    exp_iss.push_back('{cyc + 1 + k, 1'b0, base + 16'(2 * k), 16'h0000});
                    exp_fill.push_back('{cyc + 1 + k + LAT, pick_d, 3'(k), mem_word(base + 16'(2 * k))});
                end
                exp_done.push_back('{cyc + BW + LAT, pick_d});
                grant_cyc = cyc;
                free_cyc  = cyc + BW + LAT + 1;
                busy_end  = free_cyc;
                last_d    = pick_d;
                if (pick_d) d_drop = free_cyc;
                else i_drop = free_cyc;
            end
        end
    endtask

    // Abort the running transaction: later events vanish, requesters restart.
    task automatic do_reset();
        rst   = 1'b1;
        i_req = 1'b0;
        d_req = 1'b0;
        d_wr  = 1'b0;
        while (exp_iss.size() > 0 && exp_iss[$].cyc > cyc) void'(exp_iss.pop_back());
        while (exp_fill.size() > 0 && exp_fill[$].cyc > cyc) void'(exp_fill.pop_back());
        while (exp_done.size() > 0 && exp_done[$].cyc > cyc) void'(exp_done.pop_back());
        busy_end   = cyc + 1;
        free_cyc   = cyc + LAT + 3;
        hold_until = free_cyc;
        last_d     = 1'b0;
        i_drop     = -1;
        d_drop     = -1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(cyc >= free_cyc && !i_req && !d_req && !d_wr) && n < 200) begin
            begin_cycle();
            end_cycle();
            n++;
        end
        if (n >= 200) chk(1'b0, "idle_timeout", 64'(n), 64'd200);
    endtask

    task automatic random_stim();
        if (!i_req && cyc > i_drop && cyc >= hold_until && $urandom_range(0, 3) == 0) begin
            i_req  = 1'b1;
            i_addr = 16'($urandom);
        end
        if (!d_req && !d_wr && cyc > d_drop && cyc >= hold_until && $urandom_range(0, 3) == 0) begin
            d_addr = 16'($urandom);
            if ($urandom_range(0, 2) == 0) begin
                d_wr    = 1'b1;
                d_wdata = 16'($urandom);
            end else begin
                d_req = 1'b1;
            end
        end
        if (cyc > grant_cyc + 1 && cyc < busy_end - 1 && $urandom_range(0, 149) == 0)
            do_reset();
    endtask

    initial begin
        rst = 1'b1;
        i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
        i_addr = 16'h0000; d_addr = 16'h0000; d_wdata = 16'h0000;
        mem_rdata = 16'h0000; mem_valid = 1'b0;

        begin_cycle();
        end_cycle();

        // I fill alone from a mid-block address.
        begin_cycle();
        i_req = 1'b1; i_addr = 16'h0136;
        end_cycle();
        wait_idle();

        // Simultaneous fills, twice, to exercise alternation.
        for (int r = 0; r < 2; r++) begin
            begin_cycle();
            i_req = 1'b1; i_addr = 16'h4A10 + 16'(r * 64);
            d_req = 1'b1; d_addr = 16'h7F3E - 16'(r * 64);
            end_cycle();
            wait_idle();
        end

        // Write-through.
        begin_cycle();
        d_wr = 1'b1; d_addr = 16'h2004; d_wdata = 16'hBEEF;
        end_cycle();
        wait_idle();

        // Stray memory returns while idle.
        stray_en = 1'b1;
        repeat (12) begin
            begin_cycle();
            end_cycle();
        end

        // Reset in the middle of a D fill.
        begin_cycle();
        d_req = 1'b1; d_addr = 16'h55A2;
        end_cycle();
        repeat (6) begin
            begin_cycle();
            end_cycle();
        end
        begin_cycle();
        do_reset();
        end_cycle();
        wait_idle();

        // Randomized traffic with occasional resets and stray returns.
        repeat (3000) begin
            begin_cycle();
            random_stim();
            end_cycle();
        end
        wait_idle();
        stray_en = 1'b0;
        repeat (LAT + 4) begin
            begin_cycle();
            end_cycle();
        end
        chk(exp_iss.size() == 0, "issue_leftover", 64'(exp_iss.size()), 64'd0);
        chk(exp_fill.size() == 0, "fill_leftover", 64'(exp_fill.size()), 64'd0);
        chk(exp_done.size() == 0, "done_leftover", 64'(exp_done.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
